row_hist_tracker: RTL and testbench
===================================

Name: row_hist_tracker

Overview:
Parametrised row-history buffer for RowHammer throttling. It keeps a time-ordered FIFO of recently activated row addresses, each with a timestamp, and retires each entry exactly tAI after insertion. Each cycle it looks up a row address and reports the match count and the cycles until the oldest match expires. It sits beside the per-bank activation scheduler, which uses match_cnt and wait_cycles to delay ACTs.

Parameters:
CK_PERIOD, 500, clock period in ps.
tAI, 473010, entry lifetime in ps.
DEPTH, 16, entry count, any value >= 2 (not restricted to a power of two).
ADDR_WIDTH, 16, row address width.
Derived (localparam) NCK = tAI/CK_PERIOD.
Derived (localparam) TS_W = $clog2(NCK+DEPTH+2).
Derived (localparam) CNT_W = $clog2(DEPTH+1).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
row_addr  in  ADDR_WIDTH  lookup and insert address
insert_valid  in  1  insert row_addr this cycle
insert_ready  out  1  insert will be accepted this cycle
overflow  out  1  registered 1-cycle pulse: an insert was dropped
match  out  1  at least one live entry equals row_addr
match_cnt  out  CNT_W  number of live entries equal to row_addr
wait_cycles  out  TS_W  NCK minus the largest age among matching live entries; 0 if no match
occupancy  out  CNT_W  valid entry count, registered
full  out  1  occupancy == DEPTH
empty  out  1  occupancy == 0

Behaviour:
- Reset (async, immediate): head=0, tail=0, all valid=0, stamp=0, occupancy=0, overflow=0. Consequently empty=1, full=0, insert_ready=1, match=0, match_cnt=0, wait_cycles=0. Address and timestamp arrays are not reset.
- stamp: free-running TS_W-bit counter, +1 per cycle, wraps.
- Age: age = stamp - ts, modulo 2^TS_W. TS_W guarantees no aliasing even when retirement lags by up to DEPTH cycles.
- Live entry: valid && age < NCK. Stale entry: valid && age >= NCK.
- Retire: at most one per cycle, head only. When the head is stale, clear its valid bit and advance head (modulo DEPTH) at the clock edge.
- Stale non-head entries are masked from lookup by the age test, even though they still occupy slots.
- Insert acceptance: insert_ready = !full || head_stale, combinational.
- Insert accepted (insert_valid && insert_ready): write addr, ts=stamp and valid=1 at tail; tail advances modulo DEPTH.
- Insert dropped (insert_valid && !insert_ready): the entry is discarded and overflow=1 on the next cycle.
- Simultaneous retire and insert: occupancy is unchanged. Retire alone: -1. Insert alone: +1.
- Lookup: purely combinational on registered contents, 0-cycle latency. An insert in the same cycle is not visible until the next cycle.
- wait_cycles: compute a max-reduction of ages over matching live entries, then output NCK - max_age. The range is 1..NCK when match=1.
- Pointer wrap: head and tail wrap from DEPTH-1 to 0. Full and empty are derived from occupancy, never from pointer equality.

Optional Feature:
Macro ROW_HIST_FLUSH_EN.
- Defined: adds input port flush (1 bit). When flush=1, at the next edge all valid bits clear, head=tail=0 and occupancy=0. Flush has priority over a same-cycle insert, which is discarded without an overflow pulse. stamp is unaffected.
- Undefined: no flush port. Entries leave only through age retirement or reset.

Test Plan:
Bench parameters for all scenarios: CK_PERIOD=1000, tAI=20000 (NCK=20), DEPTH=4, ADDR_WIDTH=16.
1. Release rst, idle 3 cycles -> empty=1, full=0, occupancy=0, insert_ready=1, match=0, match_cnt=0, wait_cycles=0, overflow=0.
2. Insert 0x00AA at age-reference cycle 0, look up 0x00AA at age 5 -> match=1, match_cnt=1, wait_cycles=15. At age 19: wait_cycles=1. At age 20: match=0, and the entry retires at that edge so empty=1 next cycle.
3. Insert 0x1,0x2,0x3,0x4 on consecutive cycles -> full=1, insert_ready=0. Insert 0x5 one cycle later -> dropped, overflow=1 for exactly 1 cycle. Insert 0x6 when the 0x1 entry reaches age 20 -> insert_ready=1, accepted, occupancy stays 4, and a later lookup of 0x1 gives match=0.
4. Insert 0x0100 at cycles 0, 3, 6; look up 0x0100 at cycle 10 -> match_cnt=3, wait_cycles=10. At cycle 21 -> match_cnt=2, wait_cycles=2.
5. Idle 300 cycles (stamp wraps several times), insert 0xBEEF, look up 5 cycles later -> match_cnt=1, wait_cycles=15, with no false matches from stale slots.
6. With 3 valid entries, assert rst between clock edges -> occupancy=0, empty=1, match=0 before the next edge. With ROW_HIST_FLUSH_EN: flush and insert in the same cycle -> occupancy=0, overflow=0.

Source files
------------

// File: rtl/row_hist_if.sv
// Bus between the activation scheduler and row_hist_tracker: lookup/insert address,
// insert handshake and the lookup/occupancy results.
// Handshake: an insert transfers on a clock edge where insert_valid && insert_ready.
// insert_ready is combinational and never depends on insert_valid.
interface row_hist_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int NCK        = 946
);
    localparam int TS_W  = $clog2(NCK + DEPTH + 2);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] row_addr;
    logic                  insert_valid;
    logic                  insert_ready;
    logic                  overflow;
    logic                  match;
    logic [CNT_W-1:0]      match_cnt;
    logic [TS_W-1:0]       wait_cycles;
    logic [CNT_W-1:0]      occupancy;
    logic                  full;
    logic                  empty;

    modport master (
        output row_addr, insert_valid,
        input  insert_ready, overflow, match, match_cnt, wait_cycles,
               occupancy, full, empty
    );

    modport slave (
        input  row_addr, insert_valid,
        output insert_ready, overflow, match, match_cnt, wait_cycles,
               occupancy, full, empty
    );
endinterface

// File: rtl/row_hist_tracker.sv
// Time-ordered row-activation history with fixed-lifetime retirement and per-cycle lookup.
// Optional macro ROW_HIST_FLUSH_EN adds a flush input that empties the buffer.
module row_hist_tracker #(
    parameter int CK_PERIOD  = 500,
    parameter int tAI        = 473010,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
`ifdef ROW_HIST_FLUSH_EN
    input  logic flush,
`endif
    row_hist_if.slave bus
);
    localparam int NCK   = tAI / CK_PERIOD;
    localparam int TS_W  = $clog2(NCK + DEPTH + 2);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [TS_W-1:0]  NCK_TS    = TS_W'(NCK);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [TS_W-1:0]       ts_mem   [DEPTH];
    logic [DEPTH-1:0]      valid;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [TS_W-1:0]       stamp;
    logic [CNT_W-1:0]      occ;
    logic                  ovf;

    logic [TS_W-1:0]       age [DEPTH];
    logic [DEPTH-1:0]      live;
    logic                  head_stale;
    logic                  is_full;
    logic                  ready;
    logic                  do_flush;
    logic                  accept;
    logic                  drop;
    logic                  retire;
    logic [CNT_W-1:0]      hit_cnt;
    logic [TS_W-1:0]       max_age;

`ifdef ROW_HIST_FLUSH_EN
    assign do_flush = flush;
`else
    assign do_flush = 1'b0;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Modular age: TS_W leaves headroom for entries whose retirement lags behind.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age[i]  = stamp - ts_mem[i];
            live[i] = valid[i] && (age[i] < NCK_TS);
        end
    end

    assign head_stale = valid[head] && !(age[head] < NCK_TS);
    assign is_full    = (occ == DEPTH_CNT);
    assign ready      = !is_full || head_stale;
    assign retire     = head_stale;
    assign accept     = bus.insert_valid && ready && !do_flush;
    assign drop       = bus.insert_valid && !ready;

    // Lookup over live entries only; stale slots still hold old addresses.
    always_comb begin
        hit_cnt = '0;
        max_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && (addr_mem[i] == bus.row_addr)) begin
                hit_cnt = hit_cnt + CNT_W'(1);
                if (age[i] > max_age) begin
                    max_age = age[i];
                end
            end
        end
    end

    assign bus.insert_ready = ready;
    assign bus.overflow     = ovf;
    assign bus.match        = (hit_cnt != '0);
    assign bus.match_cnt    = hit_cnt;
    assign bus.wait_cycles  = (hit_cnt != '0) ? (NCK_TS - max_age) : '0;
    assign bus.occupancy    = occ;
    assign bus.full         = is_full;
    assign bus.empty        = (occ == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stamp <= '0;
            head  <= '0;
            tail  <= '0;
            valid <= '0;
            occ   <= '0;
            ovf   <= 1'b0;
        end else begin
            stamp <= stamp + TS_W'(1);
            if (do_flush) begin
                valid <= '0;
                head  <= '0;
                tail  <= '0;
                occ   <= '0;
                ovf   <= 1'b0;
            end else begin
                ovf <= drop;
                if (retire) begin
                    valid[head] <= 1'b0;
                    head        <= ptr_inc(head);
                end
                // When full, tail == head: this set must override the clear above.
                if (accept) begin
                    valid[tail] <= 1'b1;
                    tail        <= ptr_inc(tail);
                end
                case ({accept, retire})
                    2'b10:   occ <= occ + CNT_W'(1);
                    2'b01:   occ <= occ - CNT_W'(1);
                    default: occ <= occ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_mem[tail] <= bus.row_addr;
            ts_mem[tail]   <= stamp;
        end
    end
endmodule

// File: tb/tb_row_hist_tracker.sv
// Self-checking bench for row_hist_tracker: directed scenarios plus random traffic
// compared against a queue-based model of insertion times.
module tb_row_hist_tracker;
    localparam int CKP   = 1000;
    localparam int TAI   = 20000;
    localparam int NCK   = TAI / CKP;
    localparam int DEPTH = 4;
    localparam int AW    = 16;

    typedef struct {
        logic [AW-1:0] addr;
        int            t;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush_drv = 1'b0;

    row_hist_if #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .NCK(NCK)) bus ();

    row_hist_tracker #(
        .CK_PERIOD(CKP), .tAI(TAI), .DEPTH(DEPTH), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef ROW_HIST_FLUSH_EN
        .flush(flush_drv),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO of (address, insertion cycle); ages are plain integer differences.
    entry_t mq[$];
    int     now_t   = 0;
    logic   exp_ovf = 1'b0;
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, exp, now_t);
        end
    endtask

    function automatic logic model_head_stale();
        return (mq.size() > 0) && ((now_t - mq[0].t) >= NCK);
    endfunction

    task automatic check_all();
        int cnt;
        int maxa;
        int a;
        cnt  = 0;
        maxa = -1;
        foreach (mq[i]) begin
            a = now_t - mq[i].t;
            if (a < NCK && mq[i].addr == bus.row_addr) begin
                cnt++;
                if (a > maxa) maxa = a;
            end
        end
        check_val("occupancy", 32'(bus.occupancy), 32'(mq.size()));
        check_val("full", 32'(bus.full), 32'(mq.size() == DEPTH));
        check_val("empty", 32'(bus.empty), 32'(mq.size() == 0));
        check_val("insert_ready", 32'(bus.insert_ready),
                  32'((mq.size() < DEPTH) || model_head_stale()));
        check_val("overflow", 32'(bus.overflow), 32'(exp_ovf));
        check_val("match", 32'(bus.match), 32'(cnt > 0));
        check_val("match_cnt", 32'(bus.match_cnt), 32'(cnt));
        check_val("wait_cycles", 32'(bus.wait_cycles), (cnt > 0) ? 32'(NCK - maxa) : 32'd0);
    endtask

    task automatic drive(input logic [AW-1:0] a, input logic v);
        @(negedge clk);
        bus.row_addr     = a;
        bus.insert_valid = v;
        #1;
        check_all();
    endtask

    task automatic tick();
        logic rdy;
        logic v;
        entry_t e;
        v   = bus.insert_valid;
        rdy = (mq.size() < DEPTH) || model_head_stale();
        if (flush_drv) begin
            mq.delete();
            exp_ovf = 1'b0;
        end else begin
            exp_ovf = v && !rdy;
            if (model_head_stale()) void'(mq.pop_front());
            if (v && rdy) begin
                e.addr = bus.row_addr;
                e.t    = now_t;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        now_t++;
    endtask

    task automatic step(input logic [AW-1:0] a, input logic v);
        drive(a, v);
        tick();
    endtask

    initial begin
        int t0;
        bus.row_addr     = '0;
        bus.insert_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 3; i++) begin
            drive(16'h00AA, 1'b0);
            check_val("rst_empty", 32'(bus.empty), 32'd1);
            check_val("rst_ready", 32'(bus.insert_ready), 32'd1);
            check_val("rst_wait", 32'(bus.wait_cycles), 32'd0);
            tick();
        end

        // Single entry lifetime
        step(16'h00AA, 1'b1);
        for (int age = 1; age <= 21; age++) begin
            drive(16'h00AA, 1'b0);
            if (age == 5) begin
                check_val("life_cnt5", 32'(bus.match_cnt), 32'd1);
                check_val("life_wait5", 32'(bus.wait_cycles), 32'd15);
            end
            if (age == 19) check_val("life_wait19", 32'(bus.wait_cycles), 32'd1);
            if (age == 20) check_val("life_match20", 32'(bus.match), 32'd0);
            if (age == 21) check_val("life_empty21", 32'(bus.empty), 32'd1);
            tick();
        end

        // Fill, overflow, insert on retirement
        t0 = now_t;
        for (int i = 1; i <= 4; i++) step(AW'(i), 1'b1);
        drive(16'h0005, 1'b1);
        check_val("fill_full", 32'(bus.full), 32'd1);
        check_val("fill_ready", 32'(bus.insert_ready), 32'd0);
        tick();
        drive(16'h0005, 1'b0);
        check_val("ovf_pulse", 32'(bus.overflow), 32'd1);
        tick();
        drive(16'h0005, 1'b0);
        check_val("ovf_clear", 32'(bus.overflow), 32'd0);
        tick();
        while (now_t - t0 < NCK) step(16'h0006, 1'b0);
        drive(16'h0006, 1'b1);
        check_val("swap_ready", 32'(bus.insert_ready), 32'd1);
        tick();
        drive(16'h0001, 1'b0);
        check_val("swap_occ", 32'(bus.occupancy), 32'd4);
        check_val("swap_old_gone", 32'(bus.match), 32'd0);
        tick();
        repeat (NCK + 4) step(16'h0006, 1'b0);

        // Multiple matches of one row
        for (int c = 0; c <= 21; c++) begin
            drive(16'h0100, (c == 0 || c == 3 || c == 6));
            if (c == 10) begin
                check_val("multi_cnt10", 32'(bus.match_cnt), 32'd3);
                check_val("multi_wait10", 32'(bus.wait_cycles), 32'd10);
            end
            if (c == 21) begin
                check_val("multi_cnt21", 32'(bus.match_cnt), 32'd2);
                check_val("multi_wait21", 32'(bus.wait_cycles), 32'd2);
            end
            tick();
        end

        // Long idle with stamp wrap, lookups of stale addresses
        repeat (300) step(AW'($urandom_range(0, 6) << 8), 1'b0);
        step(16'hBEEF, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            drive(16'hBEEF, 1'b0);
            if (c == 5) begin
                check_val("wrap_cnt", 32'(bus.match_cnt), 32'd1);
                check_val("wrap_wait", 32'(bus.wait_cycles), 32'd15);
            end
            tick();
        end

        // Random traffic on a small address set
        for (int i = 0; i < 600; i++)
            step(AW'($urandom_range(0, 5)), ($urandom_range(0, 2) == 0));
        repeat (NCK + 4) step(16'h0000, 1'b0);

        // Asynchronous reset mid-cycle
        for (int i = 0; i < 3; i++) step(AW'(16'h0200 + i), 1'b1);
        @(negedge clk);
        bus.row_addr     = 16'h0200;
        bus.insert_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        mq.delete();
        exp_ovf = 1'b0;
        check_val("arst_occ", 32'(bus.occupancy), 32'd0);
        check_val("arst_empty", 32'(bus.empty), 32'd1);
        check_val("arst_match", 32'(bus.match), 32'd0);
        @(negedge clk);
        rst = 1'b0;

`ifdef ROW_HIST_FLUSH_EN
        for (int i = 0; i < 4; i++) step(AW'(16'h0300 + i), 1'b1);
        flush_drv = 1'b1;
        step(16'h0304, 1'b1);
        flush_drv = 1'b0;
        drive(16'h0300, 1'b0);
        check_val("flush_occ", 32'(bus.occupancy), 32'd0);
        check_val("flush_ovf", 32'(bus.overflow), 32'd0);
        check_val("flush_match", 32'(bus.match), 32'd0);
        tick();
        repeat (8) step(AW'(16'h0300 + $urandom_range(0, 3)), ($urandom_range(0, 1) == 0));
`endif
        repeat (4) step(16'h0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
